// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the IF stage: word widths, the held {pc, inst} entry
// and the word-alignment helper used to form the request address.
package inst_fetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    localparam logic [INST_W-1:0]      ZERO_WORD = '0;
    localparam logic [INST_ADDR_W-1:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } if_entry_t;

    function automatic logic [INST_ADDR_W-1:0] align_word(input logic [INST_ADDR_W-1:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/inst_fetch_next_pc.sv
// Next-PC priority mux for the fetch stage: flush > branch input > pending branch > pc+4.
// The PC only moves on a flush or when the held instruction leaves for IF/ID.
module inst_fetch_next_pc
    import inst_fetch_pkg::*;
(
    input  logic                   flush,
    input  logic [INST_ADDR_W-1:0] new_pc,
    input  logic                   advance,
    input  logic                   branch_flag,
    input  logic [INST_ADDR_W-1:0] branch_target,
    input  logic                   br_pend,
    input  logic [INST_ADDR_W-1:0] br_target,
    input  logic [INST_ADDR_W-1:0] pc,
    output logic [INST_ADDR_W-1:0] pc_next
);

    always_comb begin
        pc_next = pc;
        if (flush) begin
            pc_next = new_pc;
        end else if (advance) begin
            if (branch_flag) begin
                pc_next = branch_target;
            end else if (br_pend) begin
                pc_next = br_target;
            end else begin
                pc_next = pc + PC_STEP;
            end
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// IF stage: owns the PC, issues one-outstanding requests on the instruction port and holds
// one {pc, inst} for IF/ID. Optional misaligned-PC fault path is built with IF_ADEL_CHECK_EN.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             stall,
    input  logic                   flush,
    input  logic [INST_ADDR_W-1:0] new_pc,
    input  logic                   branch_flag_i,
    input  logic [INST_ADDR_W-1:0] branch_target_address_i,
    output logic                   inst_req,
    output logic [INST_ADDR_W-1:0] inst_addr,
    input  logic                   inst_addr_ok,
    input  logic                   inst_data_ok,
    input  logic [INST_W-1:0]      inst_rdata,
    output logic [INST_ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0]      if_inst,
    output logic                   stallreq_from_if
`ifdef IF_ADEL_CHECK_EN
    ,
    output logic                   if_adel
`endif
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

    fetch_state_e           state_q, state_d;
    logic [INST_ADDR_W-1:0] pc_q, pc_d;
    logic                   br_pend_q, br_pend_d;
    logic [INST_ADDR_W-1:0] br_target_q, br_target_d;
    if_entry_t              held_q, held_d;
    logic                   advance;
    logic                   misaligned;

    // Only stall[0] gates this stage; the other bits belong to later stages.
    logic unused_stall_bits;
    assign unused_stall_bits = ^stall[5:1];

    assign advance = (state_q == ST_HOLD) && !stall[0];

`ifdef IF_ADEL_CHECK_EN
    logic adel_q, adel_d;
    assign misaligned = (pc_q[1:0] != 2'b00);
    assign if_adel    = adel_q;
`else
    assign misaligned = 1'b0;
`endif

    assign inst_req         = !rst && (state_q == ST_REQ) && !misaligned;
    assign inst_addr        = align_word(pc_q);
    assign if_pc            = held_q.pc;
    assign if_inst          = held_q.inst;
    assign stallreq_from_if = (state_q != ST_HOLD);

    inst_fetch_next_pc u_next_pc (
        .flush         (flush),
        .new_pc        (new_pc),
        .advance       (advance),
        .branch_flag   (branch_flag_i),
        .branch_target (branch_target_address_i),
        .br_pend       (br_pend_q),
        .br_target     (br_target_q),
        .pc            (pc_q),
        .pc_next       (pc_d)
    );

    always_comb begin
        state_d     = state_q;
        br_pend_d   = br_pend_q;
        br_target_d = br_target_q;
        held_d      = held_q;
`ifdef IF_ADEL_CHECK_EN
        adel_d      = adel_q;
`endif
        if (flush) begin
            br_pend_d = 1'b0;
            held_d    = '{pc: ZERO_WORD, inst: ZERO_WORD};
`ifdef IF_ADEL_CHECK_EN
            adel_d    = 1'b0;
`endif
            // A read already accepted by memory will still return; swallow it in DROP.
            unique case (state_q)
                ST_REQ:  state_d = (inst_req && inst_addr_ok) ? ST_DROP : ST_REQ;
                ST_WAIT: state_d = inst_data_ok ? ST_REQ : ST_DROP;
                ST_DROP: state_d = inst_data_ok ? ST_REQ : ST_DROP;
                default: state_d = ST_REQ;
            endcase
        end else begin
            unique case (state_q)
                ST_REQ: begin
`ifdef IF_ADEL_CHECK_EN
                    if (misaligned) begin
                        state_d = ST_HOLD;
                        held_d  = '{pc: pc_q, inst: ZERO_WORD};
                        adel_d  = 1'b1;
                    end else
`endif
                    if (inst_addr_ok) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (inst_data_ok) begin
                        state_d = ST_HOLD;
                        held_d  = '{pc: pc_q, inst: inst_rdata};
                    end
                end
                ST_HOLD: begin
                    if (!stall[0]) begin
                        state_d   = ST_REQ;
                        br_pend_d = 1'b0;
                        held_d    = '{pc: ZERO_WORD, inst: ZERO_WORD};
`ifdef IF_ADEL_CHECK_EN
                        adel_d    = 1'b0;
`endif
                    end
                end
                default: begin
                    if (inst_data_ok) begin
                        state_d = ST_REQ;
                    end
                end
            endcase
            // A branch that cannot steer the PC this cycle is remembered; a newer one wins.
            if (branch_flag_i && !advance) begin
                br_pend_d   = 1'b1;
                br_target_d = branch_target_address_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_REQ;
            pc_q        <= RESET_PC;
            br_pend_q   <= 1'b0;
            br_target_q <= ZERO_WORD;
            held_q      <= '{pc: ZERO_WORD, inst: ZERO_WORD};
`ifdef IF_ADEL_CHECK_EN
            adel_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            br_pend_q   <= br_pend_d;
            br_target_q <= br_target_d;
            held_q      <= held_d;
`ifdef IF_ADEL_CHECK_EN
            adel_q      <= adel_d;
`endif
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: expected request addresses and delivered {pc, inst}
// are queued as stimulus is planned and checked as the DUT produces them.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq_from_if;
`ifdef IF_ADEL_CHECK_EN
    logic        if_adel;
`endif

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .inst_req                (inst_req),
        .inst_addr               (inst_addr),
        .inst_addr_ok            (inst_addr_ok),
        .inst_data_ok            (inst_data_ok),
        .inst_rdata              (inst_rdata),
        .if_pc                   (if_pc),
        .if_inst                 (if_inst),
        .stallreq_from_if        (stallreq_from_if)
`ifdef IF_ADEL_CHECK_EN
        ,
        .if_adel                 (if_adel)
`endif
    );

    typedef struct packed { logic [31:0] pc; logic [31:0] inst; } del_t;
    typedef struct packed { logic [31:0] addr; logic [7:0] cnt; } mem_t;

    logic [31:0] exp_addr_q[$];
    del_t        exp_del_q[$];
    mem_t        mem_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int prev_cap = 0;
    int lat_min  = 1;
    int lat_max  = 1;
    bit lat_chk  = 1'b0;
    bit rand_aok = 1'b0;
    bit rand_stl = 1'b0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            a = start + 32'(4 * i);
            exp_addr_q.push_back(a);
            exp_del_q.push_back('{pc: a, inst: memfn(a)});
        end
    endtask

    // Observe the cycle's handshakes and held entry before the edge that acts on them.
    task automatic sample();
        cyc++;
        if (inst_req && inst_addr_ok) begin
            mem_t m;
            if (exp_addr_q.size() == 0) check_eq("unexpected_req", {31'b0, inst_req}, 32'd0);
            else check_eq("req_addr", inst_addr, exp_addr_q.pop_front());
            m.addr = inst_addr;
            m.cnt  = 8'($urandom_range(lat_max, lat_min));
            mem_q.push_back(m);
            $display("cyc %0d: request addr=%08h", cyc, inst_addr);
        end
        if (!stallreq_from_if) begin
            if (exp_del_q.size() == 0) begin
                check_eq("unexpected_hold", {31'b0, stallreq_from_if}, 32'd1);
            end else begin
                check_eq("if_pc", if_pc, exp_del_q[0].pc);
                check_eq("if_inst", if_inst, exp_del_q[0].inst);
                if (flush || !stall[0]) begin
                    $display("cyc %0d: %s pc=%08h inst=%08h", cyc, flush ? "flushed" : "delivered", if_pc, if_inst);
                    exp_del_q.delete(0);
                    if (!flush && lat_chk && prev_cap > 0) check_eq("latency", cyc - prev_cap, 32'd3);
                    if (!flush) prev_cap = cyc;
                end
            end
        end else begin
            check_eq("idle_pc", if_pc, 32'd0);
            check_eq("idle_inst", if_inst, 32'd0);
        end
    endtask

    // In-order memory: each accepted read answers after its own latency.
    task automatic mem_update();
        inst_data_ok = 1'b0;
        inst_rdata   = 32'hDEAD_BEEF;
        if (mem_q.size() > 0) begin
            mem_t m;
            m = mem_q[0];
            if (m.cnt > 8'd1) begin
                m.cnt    = m.cnt - 8'd1;
                mem_q[0] = m;
            end else begin
                inst_data_ok = 1'b1;
                inst_rdata   = memfn(m.addr);
                mem_q.delete(0);
            end
        end
        inst_addr_ok = rand_aok ? ($urandom_range(1, 0) == 1) : 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        mem_update();
    endtask

    // Run until the last queued instruction is held, then keep it there with stall[0].
    task automatic run_until_parked(input int max);
        bit ok;
        for (int i = 0; i < max; i++) begin
            if (!stallreq_from_if && exp_del_q.size() == 1) begin
                stall = 6'b000001;
                return;
            end
            stall = (rand_stl && $urandom_range(3, 0) == 0) ? 6'b000001 : 6'b000000;
            tick();
        end
        ok = !stallreq_from_if && exp_del_q.size() == 1;
        check_eq("park_timeout", {31'b0, ok}, 32'd1);
        stall = 6'b000001;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; stall = '0; flush = 1'b0; new_pc = '0;
        branch_flag_i = 1'b0; branch_target_address_i = '0;
        inst_addr_ok = 1'b1; inst_data_ok = 1'b0; inst_rdata = '0;
        #2;
        check_eq("rst_req", {31'b0, inst_req}, 32'd0);
        check_eq("rst_if_pc", if_pc, 32'd0);
        check_eq("rst_if_inst", if_inst, 32'd0);
        check_eq("rst_stallreq", {31'b0, stallreq_from_if}, 32'd1);
        check_eq("rst_addr", inst_addr, 32'hBFC0_0000);

        // Sequential fetch from reset with a one-cycle memory.
        push_seq(32'hBFC0_0000, 3);
        @(posedge clk); #1;
        rst = 1'b0;
        lat_chk = 1'b1;
        run_until_parked(50);
        lat_chk = 1'b0;

        // Held in HOLD for five cycles, then resume at pc+4.
        repeat (5) begin
            stall = 6'b000001;
            tick();
            check_eq("stall_req", {31'b0, inst_req}, 32'd0);
            check_eq("stall_pc", inst_addr, 32'hBFC0_0008);
        end
        push_seq(32'hBFC0_000C, 2);
        run_until_parked(50);

        // Two branch pulses while the delay slot is outstanding; the later one wins.
        lat_min = 3; lat_max = 3;
        push_seq(32'hBFC0_0014, 1);
        push_seq(32'h8000_1000, 2);
        stall = '0;
        tick();
        tick();
        branch_flag_i = 1'b1; branch_target_address_i = 32'h9000_0000;
        tick();
        branch_target_address_i = 32'h8000_1000;
        tick();
        branch_flag_i = 1'b0;
        run_until_parked(100);

        // Flush while a read is outstanding: its data must be thrown away.
        exp_addr_q.push_back(32'h8000_1008);
        push_seq(32'hBFC0_0380, 2);
        stall = '0;
        tick();
        tick();
        flush = 1'b1; new_pc = 32'hBFC0_0380;
        tick();
        flush = 1'b0;
        #1;
        check_eq("drop_req", {31'b0, inst_req}, 32'd0);
        run_until_parked(100);

        // Pending branch, then flush in HOLD alongside stall[0]=0: flush wins, pending cleared.
        lat_min = 1; lat_max = 1;
        branch_flag_i = 1'b1; branch_target_address_i = 32'h8000_2000;
        tick();
        branch_flag_i = 1'b0;
        push_seq(32'hBFC0_0380, 2);
        stall = '0; flush = 1'b1; new_pc = 32'hBFC0_0380;
        tick();
        flush = 1'b0;
        run_until_parked(50);

        // PC wrap past the top of the address space.
        lat_min = 2; lat_max = 2;
        push_seq(32'hFFFF_FFF8, 4);
        flush = 1'b1; new_pc = 32'hFFFF_FFF8;
        tick();
        flush = 1'b0;
        run_until_parked(100);

        // Random address acceptance, latency and stalls.
        lat_min = 1; lat_max = 4; rand_aok = 1'b1; rand_stl = 1'b1;
        push_seq(32'h0000_0008, 8);
        run_until_parked(400);
        rand_aok = 1'b0; rand_stl = 1'b0;
        check_eq("addr_q_left", exp_addr_q.size(), 32'd0);

`ifdef IF_ADEL_CHECK_EN
        // Misaligned flush target: no request, fault entry held.
        exp_del_q.push_back('{pc: 32'h8000_0002, inst: 32'd0});
        flush = 1'b1; new_pc = 32'h8000_0002;
        tick();
        flush = 1'b0;
        check_eq("adel_req", {31'b0, inst_req}, 32'd0);
        run_until_parked(20);
        check_eq("adel_flag", {31'b0, if_adel}, 32'd1);
        check_eq("adel_stallreq", {31'b0, stallreq_from_if}, 32'd0);
        check_eq("adel_req_hold", {31'b0, inst_req}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
